// File: rtl/mem_bus_decoder_pkg.sv
// Shared types and constants for the data-bus decoder: FSM states, fault cause
// codes and the default RAM/CLINT region map.
package mem_decode_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_RESP = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'b00,
    CAUSE_UNMAPPED = 2'b01,
    CAUSE_TIMEOUT  = 2'b10
  } cause_t;

  localparam logic [31:0] RAM_BASE   = 32'h0000_0000;
  localparam logic [31:0] RAM_MASK   = 32'hFFFF_0000;
  localparam logic [31:0] CLINT_BASE = 32'hFFFF_0000;
  localparam logic [31:0] CLINT_MASK = 32'hFFFF_FFE0;

endpackage

// File: rtl/mem_bus_decoder_if.sv
// Core-side load/store port of the decoder: request handshake plus the
// single-cycle response. The core is the master, the decoder the slave.
interface mem_bus_decoder_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) ();

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_W-1:0]     req_addr;
  logic [DATA_W-1:0]     req_wdata;
  logic [DATA_W/8-1:0]   req_be;
  logic                  rsp_valid;
  logic [DATA_W-1:0]     rsp_rdata;
  logic                  rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/mem_bus_decoder_addr_region_match.sv
// Combinational N-way base/mask compare; the lowest matching region index wins.
module addr_region_match
  import mem_decode_pkg::*;
#(
  parameter int unsigned                    NUM_REGIONS = 3,
  parameter int unsigned                    ADDR_W      = 32,
  parameter logic [NUM_REGIONS*ADDR_W-1:0]  REGION_BASE = '0,
  parameter logic [NUM_REGIONS*ADDR_W-1:0]  REGION_MASK = '0,
  parameter int unsigned                    IDX_W       = 2
) (
  input  logic [ADDR_W-1:0] addr,
  output logic              hit,
  output logic [IDX_W-1:0]  idx
);

  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int unsigned k = 0; k < NUM_REGIONS; k++) begin
      if (!hit && ((addr & REGION_MASK[k*ADDR_W +: ADDR_W]) ==
                   REGION_BASE[k*ADDR_W +: ADDR_W])) begin
        hit = 1'b1;
        idx = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/mem_bus_decoder.sv
// Single-master data-bus decoder: one outstanding access, one-hot slave select,
// error response and sticky fault capture for unmapped accesses.
// Optional BUSY timeout enabled by defining MEM_DECODE_TIMEOUT_EN.
module mem_bus_decoder
  import mem_decode_pkg::*;
#(
  parameter int unsigned                   NUM_REGIONS    = 3,
  parameter int unsigned                   ADDR_W         = 32,
  parameter int unsigned                   DATA_W         = 32,
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE    = {32'h8000_0100, CLINT_BASE, RAM_BASE},
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_MASK    = {32'hFFFF_FF00, CLINT_MASK, RAM_MASK},
  parameter int unsigned                   TIMEOUT_CYCLES = 255
) (
  input  logic                          clk,
  input  logic                          rst_n,
  mem_bus_decoder_if.slave              core,
  output logic [NUM_REGIONS-1:0]        s_sel,
  output logic                          s_we,
  output logic [ADDR_W-1:0]             s_addr,
  output logic [DATA_W-1:0]             s_wdata,
  output logic [DATA_W/8-1:0]           s_be,
  input  logic [NUM_REGIONS-1:0]        s_ack,
  input  logic [NUM_REGIONS*DATA_W-1:0] s_rdata,
  output logic                          fault_valid,
  output logic [ADDR_W-1:0]             fault_addr,
  output logic                          fault_we,
  output logic [1:0]                    fault_cause,
  input  logic                          fault_clr,
  output logic [7:0]                    err_count
);

  localparam int unsigned IDX_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;
  localparam int unsigned BE_W  = DATA_W / 8;

  if (NUM_REGIONS < 1 || NUM_REGIONS > 8) begin : g_bad_regions
    $error("NUM_REGIONS must be in 1..8");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..255");
  end

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [BE_W-1:0]     be_q, be_d;
  logic                we_q, we_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                err_q, err_d;
  cause_t              cause_q, cause_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                fault_valid_q, fault_valid_d;
  logic [ADDR_W-1:0]   fault_addr_q, fault_addr_d;
  logic                fault_we_q, fault_we_d;
  cause_t              fault_cause_q, fault_cause_d;
  logic [7:0]          err_cnt_q, err_cnt_d;
`ifdef MEM_DECODE_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0]          tmo_cnt_q, tmo_cnt_d;
`endif

  logic                match_hit;
  logic [IDX_W-1:0]    match_idx;
  logic                ack_sel;
  logic [DATA_W-1:0]   rdata_sel;
  logic                err_rsp;

  addr_region_match #(
    .NUM_REGIONS (NUM_REGIONS),
    .ADDR_W      (ADDR_W),
    .REGION_BASE (REGION_BASE),
    .REGION_MASK (REGION_MASK),
    .IDX_W       (IDX_W)
  ) u_match (
    .addr (core.req_addr),
    .hit  (match_hit),
    .idx  (match_idx)
  );

  // Only the selected slave's ack and data are looked at; others are ignored.
  always_comb begin
    ack_sel   = 1'b0;
    rdata_sel = '0;
    for (int unsigned k = 0; k < NUM_REGIONS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        ack_sel   = s_ack[k];
        rdata_sel = s_rdata[k*DATA_W +: DATA_W];
      end
    end
  end

  assign err_rsp = (state_q == ST_RESP) && err_q;

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    be_d          = be_q;
    we_d          = we_q;
    idx_d         = idx_q;
    err_d         = err_q;
    cause_d       = cause_q;
    rdata_d       = rdata_q;
    fault_valid_d = fault_valid_q;
    fault_addr_d  = fault_addr_q;
    fault_we_d    = fault_we_q;
    fault_cause_d = fault_cause_q;
    err_cnt_d     = err_cnt_q;
`ifdef MEM_DECODE_TIMEOUT_EN
    tmo_cnt_d     = tmo_cnt_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (core.req_valid) begin
          addr_d  = core.req_addr;
          wdata_d = core.req_wdata;
          be_d    = core.req_be;
          we_d    = core.req_we;
          idx_d   = match_idx;
          rdata_d = '0;
          if (match_hit) begin
            err_d   = 1'b0;
            state_d = ST_BUSY;
`ifdef MEM_DECODE_TIMEOUT_EN
            tmo_cnt_d = '0;
`endif
          end else begin
            err_d   = 1'b1;
            cause_d = CAUSE_UNMAPPED;
            state_d = ST_RESP;
          end
        end
      end
      ST_BUSY: begin
        if (ack_sel) begin
          rdata_d = we_q ? '0 : rdata_sel;
          state_d = ST_RESP;
`ifdef MEM_DECODE_TIMEOUT_EN
        end else if (tmo_cnt_q == TMO_LAST) begin
          err_d   = 1'b1;
          cause_d = CAUSE_TIMEOUT;
          state_d = ST_RESP;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 8'd1;
`endif
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // A clear coinciding with a new error lets the new error through.
    if (err_rsp && (!fault_valid_q || fault_clr)) begin
      fault_valid_d = 1'b1;
      fault_addr_d  = addr_q;
      fault_we_d    = we_q;
      fault_cause_d = cause_q;
    end else if (fault_clr) begin
      fault_valid_d = 1'b0;
      fault_addr_d  = '0;
      fault_we_d    = 1'b0;
      fault_cause_d = CAUSE_NONE;
    end

    if (err_rsp && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      addr_q        <= '0;
      wdata_q       <= '0;
      be_q          <= '0;
      we_q          <= 1'b0;
      idx_q         <= '0;
      err_q         <= 1'b0;
      cause_q       <= CAUSE_NONE;
      rdata_q       <= '0;
      fault_valid_q <= 1'b0;
      fault_addr_q  <= '0;
      fault_we_q    <= 1'b0;
      fault_cause_q <= CAUSE_NONE;
      err_cnt_q     <= '0;
`ifdef MEM_DECODE_TIMEOUT_EN
      tmo_cnt_q     <= '0;
`endif
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      be_q          <= be_d;
      we_q          <= we_d;
      idx_q         <= idx_d;
      err_q         <= err_d;
      cause_q       <= cause_d;
      rdata_q       <= rdata_d;
      fault_valid_q <= fault_valid_d;
      fault_addr_q  <= fault_addr_d;
      fault_we_q    <= fault_we_d;
      fault_cause_q <= fault_cause_d;
      err_cnt_q     <= err_cnt_d;
`ifdef MEM_DECODE_TIMEOUT_EN
      tmo_cnt_q     <= tmo_cnt_d;
`endif
    end
  end

  always_comb begin
    s_sel = '0;
    for (int unsigned k = 0; k < NUM_REGIONS; k++) begin
      s_sel[k] = (state_q == ST_BUSY) && (idx_q == IDX_W'(k));
    end
  end

  assign s_we           = (state_q == ST_BUSY) && we_q;
  assign s_addr         = addr_q;
  assign s_wdata        = wdata_q;
  assign s_be           = be_q;
  assign core.req_ready = (state_q == ST_IDLE);
  assign core.rsp_valid = (state_q == ST_RESP);
  assign core.rsp_err   = err_rsp;
  assign core.rsp_rdata = rdata_q;
  assign fault_valid    = fault_valid_q;
  assign fault_addr     = fault_addr_q;
  assign fault_we       = fault_we_q;
  assign fault_cause    = fault_cause_q;
  assign err_count      = err_cnt_q;

endmodule

// File: tb/tb_mem_bus_decoder.sv
// Directed self-checking bench for mem_bus_decoder with hand-computed expectations.
module tb_mem_bus_decoder;

`ifdef MEM_DECODE_TIMEOUT_EN
  localparam int unsigned TB_TMO = 4;
`else
  localparam int unsigned TB_TMO = 255;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  s_sel;
  logic        s_we;
  logic [31:0] s_addr;
  logic [31:0] s_wdata;
  logic [3:0]  s_be;
  logic [2:0]  s_ack = '0;
  logic [95:0] s_rdata = {32'h2222_2222, 32'hC1C1_0008, 32'h0000_0011};
  logic        fault_valid;
  logic [31:0] fault_addr;
  logic        fault_we;
  logic [1:0]  fault_cause;
  logic        fault_clr = 1'b0;
  logic [7:0]  err_count;

  int unsigned n_chk = 0;
  int unsigned n_err = 0;

  mem_bus_decoder_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_bus_decoder #(.NUM_REGIONS(3), .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TB_TMO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .core        (bus),
    .s_sel       (s_sel),
    .s_we        (s_we),
    .s_addr      (s_addr),
    .s_wdata     (s_wdata),
    .s_be        (s_be),
    .s_ack       (s_ack),
    .s_rdata     (s_rdata),
    .fault_valid (fault_valid),
    .fault_addr  (fault_addr),
    .fault_we    (fault_we),
    .fault_cause (fault_cause),
    .fault_clr   (fault_clr),
    .err_count   (err_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] be);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_be    = be;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_be    = '0;

    // Reset state
    #1;
    check("rst_sel", 64'(s_sel), 64'h0);
    check("rst_rsp_valid", 64'(bus.rsp_valid), 64'h0);
    check("rst_fault_valid", 64'(fault_valid), 64'h0);
    check("rst_err_count", 64'(err_count), 64'h0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    check("rdy_after_rst", 64'(bus.req_ready), 64'h1);

    // Load from RAM, ack one cycle late; a stray CLINT ack in between is ignored
    drive_req(1'b0, 32'h0000_0010, 32'h0, 4'hF);
    tick();
    bus.req_valid = 1'b0;
    s_ack = 3'b010;
    check("ram_sel_c1", 64'(s_sel), 64'h1);
    check("ram_rdy_busy", 64'(bus.req_ready), 64'h0);
    check("ram_s_addr", 64'(s_addr), 64'h10);
    check("ram_s_we", 64'(s_we), 64'h0);
    tick();
    check("ram_sel_c2", 64'(s_sel), 64'h1);
    check("ram_no_rsp", 64'(bus.rsp_valid), 64'h0);
    s_ack = 3'b001;
    tick();
    s_ack = 3'b000;
    check("ram_rsp_valid", 64'(bus.rsp_valid), 64'h1);
    check("ram_rdata", 64'(bus.rsp_rdata), 64'h11);
    check("ram_err", 64'(bus.rsp_err), 64'h0);
    check("ram_sel_off", 64'(s_sel), 64'h0);
    tick();
    check("ram_rsp_pulse", 64'(bus.rsp_valid), 64'h0);
    check("ram_rdy_back", 64'(bus.req_ready), 64'h1);

    // Load from CLINT, ack in first BUSY cycle
    drive_req(1'b0, 32'hFFFF_0008, 32'h0, 4'hF);
    tick();
    bus.req_valid = 1'b0;
    check("clint_sel", 64'(s_sel), 64'h2);
    s_ack = 3'b010;
    tick();
    s_ack = 3'b000;
    check("clint_rsp_valid", 64'(bus.rsp_valid), 64'h1);
    check("clint_rdata", 64'(bus.rsp_rdata), 64'hC1C1_0008);
    check("clint_err", 64'(bus.rsp_err), 64'h0);
    tick();

    // Mapped store to region 2: strobe, registered data, zero read data
    drive_req(1'b1, 32'h8000_0123, 32'hDEAD_BEEF, 4'h6);
    tick();
    bus.req_valid = 1'b0;
    check("st_sel", 64'(s_sel), 64'h4);
    check("st_we", 64'(s_we), 64'h1);
    check("st_wdata", 64'(s_wdata), 64'hDEAD_BEEF);
    check("st_be", 64'(s_be), 64'h6);
    s_ack = 3'b100;
    tick();
    s_ack = 3'b000;
    check("st_rsp_valid", 64'(bus.rsp_valid), 64'h1);
    check("st_rdata_zero", 64'(bus.rsp_rdata), 64'h0);
    check("st_err", 64'(bus.rsp_err), 64'h0);
    tick();

    // Unmapped store: immediate error, no select or strobe
    drive_req(1'b1, 32'h8000_0000, 32'h0000_0011, 4'hF);
    tick();
    bus.req_valid = 1'b0;
    check("um1_rsp_valid", 64'(bus.rsp_valid), 64'h1);
    check("um1_rsp_err", 64'(bus.rsp_err), 64'h1);
    check("um1_sel", 64'(s_sel), 64'h0);
    check("um1_we", 64'(s_we), 64'h0);
    tick();
    check("um1_fault_valid", 64'(fault_valid), 64'h1);
    check("um1_fault_addr", 64'(fault_addr), 64'h8000_0000);
    check("um1_fault_we", 64'(fault_we), 64'h1);
    check("um1_fault_cause", 64'(fault_cause), 64'h1);
    check("um1_err_count", 64'(err_count), 64'h1);

    // Second fault (CLINT hole) does not overwrite the held fault
    drive_req(1'b0, 32'hFFFF_0020, 32'h0, 4'hF);
    tick();
    bus.req_valid = 1'b0;
    check("um2_rsp_err", 64'(bus.rsp_err), 64'h1);
    check("um2_rdata", 64'(bus.rsp_rdata), 64'h0);
    tick();
    check("um2_fault_addr", 64'(fault_addr), 64'h8000_0000);
    check("um2_err_count", 64'(err_count), 64'h2);

    // Third fault with clear in the same cycle: new fault is loaded
    drive_req(1'b1, 32'h0001_0000, 32'h0, 4'hF);
    tick();
    bus.req_valid = 1'b0;
    fault_clr = 1'b1;
    check("um3_rsp_err", 64'(bus.rsp_err), 64'h1);
    tick();
    fault_clr = 1'b0;
    check("um3_fault_valid", 64'(fault_valid), 64'h1);
    check("um3_fault_addr", 64'(fault_addr), 64'h0001_0000);
    check("um3_fault_we", 64'(fault_we), 64'h1);
    check("um3_err_count", 64'(err_count), 64'h3);

    // Plain clear empties the fault registers but keeps the count
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    check("clr_fault_valid", 64'(fault_valid), 64'h0);
    check("clr_fault_addr", 64'(fault_addr), 64'h0);
    check("clr_err_count", 64'(err_count), 64'h3);

`ifdef MEM_DECODE_TIMEOUT_EN
    // RAM never acks: error after 4 BUSY cycles, late ack ignored
    drive_req(1'b0, 32'h0000_0020, 32'h0, 4'hF);
    tick();
    bus.req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("tmo_busy_sel", 64'(s_sel), 64'h1);
      check("tmo_no_rsp", 64'(bus.rsp_valid), 64'h0);
      tick();
    end
    check("tmo_rsp_valid", 64'(bus.rsp_valid), 64'h1);
    check("tmo_rsp_err", 64'(bus.rsp_err), 64'h1);
    check("tmo_sel_off", 64'(s_sel), 64'h0);
    s_ack = 3'b001;
    tick();
    check("tmo_fault_cause", 64'(fault_cause), 64'h2);
    check("tmo_fault_addr", 64'(fault_addr), 64'h20);
    check("tmo_err_count", 64'(err_count), 64'h4);
    check("tmo_late_rdy", 64'(bus.req_ready), 64'h1);
    tick();
    s_ack = 3'b000;
    check("tmo_late_ack", 64'(bus.rsp_valid), 64'h0);
`endif

    // Reset during BUSY aborts immediately
    drive_req(1'b0, 32'h0000_0010, 32'h0, 4'hF);
    tick();
    bus.req_valid = 1'b0;
    check("ar_sel_busy", 64'(s_sel), 64'h1);
    #1 rst_n = 1'b0;
    #1;
    check("ar_sel", 64'(s_sel), 64'h0);
    check("ar_rsp_valid", 64'(bus.rsp_valid), 64'h0);
    check("ar_s_addr", 64'(s_addr), 64'h0);
    check("ar_err_count", 64'(err_count), 64'h0);
    check("ar_fault_valid", 64'(fault_valid), 64'h0);
    #1 rst_n = 1'b1;
    tick();
    check("ar_no_rsp", 64'(bus.rsp_valid), 64'h0);
    drive_req(1'b0, 32'hFFFF_0000, 32'h0, 4'hF);
    tick();
    bus.req_valid = 1'b0;
    check("ar_new_sel", 64'(s_sel), 64'h2);
    s_ack = 3'b010;
    tick();
    s_ack = 3'b000;
    check("ar_new_rsp", 64'(bus.rsp_valid), 64'h1);
    check("ar_new_rdata", 64'(bus.rsp_rdata), 64'hC1C1_0008);
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
